// File: rtl/cpu_clk_pkg.sv
// Shared constants and types for the CPU clock-enable controller.
package cpu_clk_pkg;

    localparam int TIMER_W = 32;
    localparam int TICK_W  = 16;

    localparam logic [1:0] ST_HALT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;

    // Default periods in board-clock cycles (50 MHz board clock).
    localparam int unsigned DIV0_DEF = 50_000_000;
    localparam int unsigned DIV1_DEF = 5_000_000;
    localparam int unsigned DIV2_DEF = 500_000;
    localparam int unsigned DIV3_DEF = 50;

    typedef enum logic [1:0] {
        S_HALT = ST_HALT,
        S_RUN  = ST_RUN,
        S_STEP = ST_STEP
    } state_t;

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// Control/status bundle between the button logic, the controller and the CPU.
interface cpu_clk_ctrl_if #(
    parameter int CNT_W = cpu_clk_pkg::TICK_W
);
    logic             run_i;
    logic             step_i;
    logic             halt_i;
    logic [1:0]       speed_i;
    logic             cpu_en;
    logic             running;
    logic [CNT_W-1:0] tick_cnt;

    // Requester side: buttons/debug logic drive the requests and watch status.
    modport master (
        output run_i, step_i, halt_i, speed_i,
        input  cpu_en, running, tick_cnt
    );

    // Controller side.
    modport slave (
        input  run_i, step_i, halt_i, speed_i,
        output cpu_en, running, tick_cnt
    );
endinterface

// File: rtl/tick_gen.sv
// Period timer: counts 0..period-1 while enabled and flags the wrap one cycle later.
module tick_gen
    import cpu_clk_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [TIMER_W-1:0] period,
    output logic               tc,
    output logic               last
);

    logic [TIMER_W-1:0] timer;

    // Terminal count of the current period (combinational, used for rate resampling).
    assign last = (timer == period - TIMER_W'(1));

    // Timer with clear priority over enable; tc registered so the pulse trails TC by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
            tc    <= 1'b0;
        end else begin
            tc <= en & ~clr & last;
            if (clr) begin
                timer <= '0;
            end else if (en) begin
                timer <= last ? '0 : timer + TIMER_W'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt controller producing the CPU clock-enable pulse.
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int unsigned DIV0  = DIV0_DEF,
    parameter int unsigned DIV1  = DIV1_DEF,
    parameter int unsigned DIV2  = DIV2_DEF,
    parameter int unsigned DIV3  = DIV3_DEF,
    parameter int          CNT_W = TICK_W
)(
    input  logic           clk,
    input  logic           rst_n,
    cpu_clk_ctrl_if.slave  bus
);

    state_t             state;
    state_t             state_next;
    logic               leave_run;
    logic [TIMER_W-1:0] div_sel;
    logic               step_q;
    logic               running_q;
    logic [CNT_W-1:0]   tick_q;
    logic               tc;
    logic               last;
    logic               cpu_en;
    logic               tmr_clr;
    logic               tmr_en;

    function automatic logic [TIMER_W-1:0] period_for(input logic [1:0] sel);
        case (sel)
            2'd0:    return TIMER_W'(DIV0);
            2'd1:    return TIMER_W'(DIV1);
            2'd2:    return TIMER_W'(DIV2);
            default: return TIMER_W'(DIV3);
        endcase
    endfunction

    // Timer only advances in RUN; any other state (or leaving RUN) parks it at zero,
    // which also suppresses a pulse when halt coincides with TC.
    assign tmr_en  = (state == S_RUN);
    assign tmr_clr = (state != S_RUN) | leave_run;

    tick_gen u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .period (div_sel),
        .tc     (tc),
        .last   (last)
    );

    // Both sources are flops and can never be high together, so the OR is glitch-free.
    assign cpu_en = tc | step_q;

    // Next-state logic; a step request is ignored while a step pulse is on the wire.
    always_comb begin
        state_next = state;
        leave_run  = 1'b0;
        case (state)
            S_HALT: begin
                if (bus.run_i) begin
                    state_next = S_RUN;
                end else if (bus.step_i && !cpu_en) begin
                    state_next = S_STEP;
                end
            end
            S_RUN: begin
                if (bus.halt_i || !bus.run_i) begin
                    state_next = S_HALT;
                    leave_run  = 1'b1;
                end
            end
            S_STEP: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_HALT;
            end
        endcase
    end

    // State register with the running flag and the committed step pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_HALT;
            running_q <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            state     <= state_next;
            running_q <= (state_next == S_RUN);
            step_q    <= (state == S_STEP);
        end
    end

    // Rate latch: follows speed_i while halted, otherwise only at a period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_sel <= TIMER_W'(DIV0);
        end else if (state == S_HALT || (state == S_RUN && last)) begin
            div_sel <= period_for(bus.speed_i);
        end
    end

    // Free-running count of issued enable pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + CNT_W'(cpu_en);
        end
    end

    assign bus.cpu_en   = cpu_en;
    assign bus.running  = running_q;
    assign bus.tick_cnt = tick_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl with a deadline-based reference model.
module tb_cpu_clk_ctrl;

    localparam int unsigned D0 = 4;
    localparam int unsigned D1 = 8;
    localparam int unsigned D2 = 3;
    localparam int unsigned D3 = 2;

    logic clk;
    logic rst_n;
    logic rst_w_n;
    int   checks;
    int   errors;

    cpu_clk_ctrl_if #(.CNT_W(16)) bus ();
    cpu_clk_ctrl_if #(.CNT_W(8))  wbus ();

    cpu_clk_ctrl #(.DIV0(D0), .DIV1(D1), .DIV2(D2), .DIV3(D3), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Narrow tick counter instance so the counter wrap is reachable quickly.
    cpu_clk_ctrl #(.DIV0(D0), .DIV1(D1), .DIV2(D2), .DIV3(D3), .CNT_W(8)) dut_w (
        .clk   (clk),
        .rst_n (rst_w_n),
        .bus   (wbus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: mode 0 halted, 1 running, 2 step committed.
    // In run mode the next pulse is an absolute cycle number (deadline).
    int              m_mode;
    longint unsigned m_cyc;
    longint unsigned m_deadline;
    bit              m_en;
    int unsigned     m_cnt;
    bit              prev_en;

    function automatic int unsigned rate(input logic [1:0] s);
        case (s)
            2'd0:    return D0;
            2'd1:    return D1;
            2'd2:    return D2;
            default: return D3;
        endcase
    endfunction

    task automatic model_reset();
        m_mode     = 0;
        m_cyc      = 0;
        m_deadline = 0;
        m_en       = 1'b0;
        m_cnt      = 0;
        prev_en    = 1'b0;
    endtask

    task automatic model_edge();
        bit nxt;
        nxt = 1'b0;
        case (m_mode)
            1: begin
                if (bus.halt_i || !bus.run_i) begin
                    m_mode = 0;
                end else if (m_cyc + 1 == m_deadline) begin
                    nxt        = 1'b1;
                    m_deadline = m_cyc + 1 + rate(bus.speed_i);
                end
            end
            2: begin
                nxt    = 1'b1;
                m_mode = 0;
            end
            default: begin
                if (bus.run_i) begin
                    m_mode     = 1;
                    m_deadline = m_cyc + 1 + rate(bus.speed_i);
                end else if (bus.step_i && !m_en) begin
                    m_mode = 2;
                end
            end
        endcase
        m_cnt = (m_cnt + (m_en ? 1 : 0)) % 65536;
        m_en  = nxt;
        m_cyc++;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        checks += 4;
        if (bus.cpu_en !== m_en) begin
            errors++;
            $display("FAIL %s cyc=%0d cpu_en got %b want %b", tag, m_cyc, bus.cpu_en, m_en);
        end
        if (bus.running !== (m_mode == 1)) begin
            errors++;
            $display("FAIL %s cyc=%0d running got %b want %b", tag, m_cyc, bus.running, (m_mode == 1));
        end
        if (bus.tick_cnt !== 16'(m_cnt)) begin
            errors++;
            $display("FAIL %s cyc=%0d tick_cnt got %0d want %0d", tag, m_cyc, bus.tick_cnt, m_cnt);
        end
        if (prev_en && bus.cpu_en) begin
            errors++;
            $display("FAIL %s_back_to_back cyc=%0d cpu_en got 1 want 0", tag, m_cyc);
        end
        prev_en = bus.cpu_en;
    endtask

    task automatic do_reset();
        bus.run_i   = 1'b0;
        bus.step_i  = 1'b0;
        bus.halt_i  = 1'b0;
        bus.speed_i = 2'd0;
        rst_n       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.run_i   = 1'b1;
        bus.step_i  = 1'b1;
        bus.halt_i  = 1'b0;
        bus.speed_i = 2'd3;
        repeat (3) @(negedge clk);
        checks += 3;
        if (bus.cpu_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_cpu_en got %b want 0", bus.cpu_en);
        end
        if (bus.running !== 1'b0) begin
            errors++;
            $display("FAIL reset_running got %b want 0", bus.running);
        end
        if (bus.tick_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_tick_cnt got %0d want 0", bus.tick_cnt);
        end
        bus.run_i  = 1'b0;
        bus.step_i = 1'b0;
        rst_n      = 1'b1;
        model_reset();
        repeat (4) tick("reset_idle");
    endtask

    task automatic test_run();
        logic [31:0] mask;
        do_reset();
        tick("run_idle");
        bus.speed_i = 2'd0;
        bus.run_i   = 1'b1;
        tick("run");
        mask = '0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) tick("run");
            mask[k] = bus.cpu_en;
        end
        checks += 3;
        if (mask !== ((32'd1 << 4) | (32'd1 << 8) | (32'd1 << 12))) begin
            errors++;
            $display("FAIL run_pulse_cycles got %h want %h", mask, 32'h1110);
        end
        if (bus.tick_cnt !== 16'd3) begin
            errors++;
            $display("FAIL run_tick_cnt got %0d want 3", bus.tick_cnt);
        end
        if (bus.running !== 1'b1) begin
            errors++;
            $display("FAIL run_running got %b want 1", bus.running);
        end
        bus.run_i = 1'b0;
        tick("run_stop");
    endtask

    task automatic test_step();
        logic [31:0] mask;
        do_reset();
        tick("step_idle");
        tick("step_idle");
        mask       = '0;
        bus.step_i = 1'b1;
        mask[0]    = bus.cpu_en;
        for (int k = 1; k < 8; k++) begin
            tick("step");
            if (k == 3) bus.step_i = 1'b0;
            mask[k] = bus.cpu_en;
        end
        checks += 3;
        if (mask !== (32'd1 << 2)) begin
            errors++;
            $display("FAIL step_pulse_cycles got %h want %h", mask, 32'h4);
        end
        if (bus.tick_cnt !== 16'd1) begin
            errors++;
            $display("FAIL step_tick_cnt got %0d want 1", bus.tick_cnt);
        end
        if (bus.running !== 1'b0) begin
            errors++;
            $display("FAIL step_running got %b want 0", bus.running);
        end
    endtask

    task automatic test_speed_change();
        logic [31:0] mask;
        do_reset();
        tick("speed_idle");
        bus.speed_i = 2'd0;
        bus.run_i   = 1'b1;
        tick("speed");
        mask = '0;
        for (int k = 0; k < 22; k++) begin
            if (k > 0) tick("speed");
            if (k == 1) bus.speed_i = 2'd1;
            mask[k] = bus.cpu_en;
        end
        checks++;
        if (mask !== ((32'd1 << 4) | (32'd1 << 12) | (32'd1 << 20))) begin
            errors++;
            $display("FAIL speed_change_cycles got %h want %h", mask, 32'h101010);
        end
        bus.run_i = 1'b0;
        tick("speed_stop");
    endtask

    task automatic test_halt_tc();
        logic [31:0] mask;
        do_reset();
        tick("halt_idle");
        bus.speed_i = 2'd0;
        bus.run_i   = 1'b1;
        tick("halt");
        for (int k = 1; k <= 3; k++) tick("halt");
        bus.halt_i = 1'b1;
        bus.run_i  = 1'b0;
        tick("halt_tc");
        checks += 2;
        if (bus.cpu_en !== 1'b0) begin
            errors++;
            $display("FAIL halt_tc_cpu_en got %b want 0", bus.cpu_en);
        end
        if (bus.running !== 1'b0) begin
            errors++;
            $display("FAIL halt_tc_running got %b want 0", bus.running);
        end
        bus.halt_i = 1'b0;
        tick("halt_wait");
        tick("halt_wait");
        bus.run_i = 1'b1;
        tick("halt_rerun");
        mask = '0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick("halt_rerun");
            mask[k] = bus.cpu_en;
        end
        checks += 2;
        if (mask !== ((32'd1 << 4) | (32'd1 << 8))) begin
            errors++;
            $display("FAIL halt_rerun_cycles got %h want %h", mask, 32'h110);
        end
        if (bus.tick_cnt !== 16'd2) begin
            errors++;
            $display("FAIL halt_tick_cnt got %0d want 2", bus.tick_cnt);
        end
        bus.run_i = 1'b0;
        tick("halt_stop");
    endtask

    task automatic test_run_step_together();
        logic [31:0] mask;
        do_reset();
        tick("runstep_idle");
        bus.run_i  = 1'b1;
        bus.step_i = 1'b1;
        tick("runstep");
        bus.step_i = 1'b0;
        mask = '0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick("runstep");
            mask[k] = bus.cpu_en;
        end
        checks += 2;
        if (mask !== ((32'd1 << 4) | (32'd1 << 8))) begin
            errors++;
            $display("FAIL runstep_cycles got %h want %h", mask, 32'h110);
        end
        if (bus.tick_cnt !== 16'd2) begin
            errors++;
            $display("FAIL runstep_tick_cnt got %0d want 2", bus.tick_cnt);
        end
        bus.run_i = 1'b0;
        tick("runstep_stop");
    endtask

    task automatic test_async_reset();
        bit found;
        do_reset();
        tick("areset_idle");
        bus.speed_i = 2'd3;
        bus.run_i   = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick("areset_run");
            if (bus.cpu_en && bus.tick_cnt >= 16'd3) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL areset_timeout got no pulse want pulse within 40 cycles");
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (bus.cpu_en !== 1'b0) begin
            errors++;
            $display("FAIL areset_cpu_en got %b want 0", bus.cpu_en);
        end
        if (bus.running !== 1'b0) begin
            errors++;
            $display("FAIL areset_running got %b want 0", bus.running);
        end
        if (bus.tick_cnt !== 16'd0) begin
            errors++;
            $display("FAIL areset_tick_cnt got %0d want 0", bus.tick_cnt);
        end
        bus.run_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) tick("areset_after");
    endtask

    task automatic test_wrap();
        int seen;
        bit prev;
        wbus.run_i   = 1'b0;
        wbus.step_i  = 1'b0;
        wbus.halt_i  = 1'b0;
        wbus.speed_i = 2'd3;
        rst_w_n      = 1'b0;
        @(negedge clk);
        rst_w_n    = 1'b1;
        wbus.run_i = 1'b1;
        seen = 0;
        prev = 1'b0;
        for (int i = 0; i < 1200 && seen < 256; i++) begin
            @(negedge clk);
            if (prev) begin
                seen++;
                checks++;
                if (wbus.tick_cnt !== 8'(seen)) begin
                    errors++;
                    $display("FAIL wrap_tick_cnt pulse=%0d got %0d want %0d", seen, wbus.tick_cnt, seen % 256);
                end
            end
            prev = wbus.cpu_en;
        end
        checks++;
        if (seen != 256) begin
            errors++;
            $display("FAIL wrap_timeout got %0d pulses want 256", seen);
        end
        wbus.run_i = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 23) == 0) bus.run_i = ~bus.run_i;
            bus.step_i = ($urandom_range(0, 3) == 0);
            bus.halt_i = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 7) == 0) bus.speed_i = 2'($urandom_range(0, 3));
            tick("random");
        end
        bus.run_i  = 1'b0;
        bus.step_i = 1'b0;
        bus.halt_i = 1'b0;
        tick("random_end");
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_w_n      = 1'b0;
        wbus.run_i   = 1'b0;
        wbus.step_i  = 1'b0;
        wbus.halt_i  = 1'b0;
        wbus.speed_i = 2'd0;
        model_reset();
        test_reset();
        test_run();
        test_step();
        test_speed_change();
        test_halt_tc();
        test_run_step_together();
        test_async_reset();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
